lockpick_player: RTL and testbench

- Player-side driver for the lockpick game core's byte-stream protocol.
- On a `go` pulse it latches two 256-bit keys, issues the game start pulse (when needed) and streams key A then key B, 32 bytes each.
- It then captures the 32-byte result frame and reports a decoded outcome to the host logic.
- Sits between a host register block and the game core; connects port-for-port to the game's start / input_enable / input_data / output_valid / output_data / status.

---
 rtl/lockpick_player.sv | 138 +++++++++++++
 tb/tb_lockpick_player.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lockpick_player.sv
// lockpick_player: drives two 256-bit keys byte-by-byte into the lockpick game core,
// then captures and decodes the game's 32-byte result frame.
module lockpick_player #(
    parameter int PACE           = 0,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [255:0] key_a,
    input  logic [255:0] key_b,
    output logic         game_start,
    output logic         game_input_enable,
    output logic [7:0]   game_input_data,
    input  logic         game_output_valid,
    input  logic [7:0]   game_output_data,
    input  logic [1:0]   game_status,
    output logic         busy,
    output logic         done,
    output logic [1:0]   result,
    output logic [31:0]  rx_msg,
    output logic         msg_error,
    output logic         session_open
);
    localparam int PW = $clog2(PACE + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] PACE_L  = PW'(PACE);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, START, SEND_A, SEND_B, WAIT_RESP, RECV, DONE} state_t;
    state_t state, state_n;

    logic [255:0]  ka, kb;
    logic [4:0]    idx, idx_n, rcnt, lane;
    logic [PW-1:0] pcnt;
    logic [TW-1:0] tcnt;
    logic          accept, sending, paced, last_byte, first, step, byte_bad, frame_ok, fault;
    logic [1:0]    decoded;

    assign accept    = go && (state == IDLE || state == DONE);
    assign sending   = state == SEND_A || state == SEND_B;
    assign paced     = pcnt == PACE_L;
    assign last_byte = idx == 5'd31;
    // byte 0 of A goes out on the edge that enters SEND_A, so it follows game_start directly
    assign first     = (accept && session_open) || state == START;
    assign step      = sending && paced && !(state == SEND_B && last_byte);
    assign idx_n     = idx + 5'd1;
    assign lane      = {rcnt[1:0], 3'b000};
    assign byte_bad  = rcnt > 5'd3 && game_output_data != rx_msg[lane +: 8];
    assign decoded   = rx_msg == 32'hFACE_FACE ? 2'b10 :
                       rx_msg == 32'hBAD0_BAD0 ? 2'b01 :
                       rx_msg == 32'hDEAD_DEAD ? 2'b11 : 2'b00;
    assign frame_ok  = !msg_error && !byte_bad && decoded != 2'b00 && decoded == game_status;
    assign fault     = !game_output_valid && (state == RECV || (state == WAIT_RESP && tcnt == TO_LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n    = state;
        game_start = state == START;
        busy       = state != IDLE && state != DONE;
        case (state)
            IDLE, DONE: state_n = go ? (session_open ? SEND_A : START) : state;
            START:      state_n = SEND_A;
            SEND_A:     state_n = (paced && last_byte) ? SEND_B : SEND_A;
            SEND_B:     state_n = (paced && last_byte) ? WAIT_RESP : SEND_B;
            WAIT_RESP:  state_n = game_output_valid ? RECV : (tcnt == TO_LAST ? DONE : WAIT_RESP);
            RECV:       state_n = (!game_output_valid || rcnt == 5'd31) ? DONE : RECV;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ka                <= '0;
            kb                <= '0;
            idx               <= '0;
            rcnt              <= '0;
            pcnt              <= '0;
            tcnt              <= '0;
            game_input_enable <= 1'b0;
            game_input_data   <= '0;
            done              <= 1'b0;
            result            <= '0;
            rx_msg            <= '0;
            msg_error         <= 1'b0;
            session_open      <= 1'b0;
        end else begin
            done              <= 1'b0;
            game_input_enable <= first || step;
            tcnt              <= state == WAIT_RESP ? tcnt + TW'(1) : '0;
            if (accept) begin
                ka        <= key_a;
                kb        <= key_b;
                result    <= 2'b00;
                rx_msg    <= '0;
                msg_error <= 1'b0;
            end
            if (first) begin
                game_input_data <= state == START ? ka[7:0] : key_a[7:0];
                idx             <= '0;
                pcnt            <= '0;
            end else if (step) begin
                game_input_data <= (state == SEND_A && !last_byte) ? ka[{idx_n, 3'b000} +: 8]
                                                                   : kb[{idx_n, 3'b000} +: 8];
                idx             <= idx_n;
                pcnt            <= '0;
            end else if (sending) begin
                pcnt <= pcnt + PW'(1);
            end
            if (state == START) session_open <= 1'b1;
            if (state == WAIT_RESP && game_output_valid) begin
                rx_msg[7:0] <= game_output_data;
                rcnt        <= 5'd1;
            end
            if (fault) begin
                done         <= 1'b1;
                result       <= 2'b00;
                msg_error    <= 1'b1;
                session_open <= 1'b0;
            end
            if (state == RECV && game_output_valid) begin
                rcnt <= rcnt + 5'd1;
                if (rcnt < 5'd4) rx_msg[lane +: 8] <= game_output_data;
                else if (byte_bad) msg_error <= 1'b1;
                if (rcnt == 5'd31) begin
                    done         <= 1'b1;
                    result       <= frame_ok ? decoded : 2'b00;
                    msg_error    <= !frame_ok;
                    session_open <= frame_ok && decoded == 2'b01;
                end
            end
        end
    end
endmodule

// File: tb/tb_lockpick_player.sv
// tb_lockpick_player: randomized bench for two player instances (PACE 0 and 2),
// checked against a frame-level model of the game protocol.
module tb_lockpick_player;
    localparam int TO = 64;

    logic         clk = 0, rst = 0, go0 = 0, go2 = 0;
    logic [255:0] key_a = '0, key_b = '0;
    logic         gv = 0;
    logic [7:0]   gd = '0;
    logic [1:0]   gs = '0;

    logic s0, e0, b0, d0, er0, o0, s2, e2, b2, d2, er2, o2;
    logic [7:0]  dt0, dt2;
    logic [1:0]  r0, r2;
    logic [31:0] m0, m2;

    int n_tests = 0, n_fail = 0, cyc = 0;
    int starts0 = 0, starts2 = 0, start0_cyc = -1;
    logic open_exp = 0;
    logic [7:0] sent0[$], sent2[$];
    int sent0_cyc[$], sent2_cyc[$];

    typedef struct packed {
        logic [1:0]  res;
        logic        err;
        logic        open;
        logic [31:0] msg;
    } outcome_t;

    lockpick_player #(.PACE(0), .TIMEOUT_CYCLES(TO)) dut0 (
        .clk(clk), .rst(rst), .go(go0), .key_a(key_a), .key_b(key_b),
        .game_start(s0), .game_input_enable(e0), .game_input_data(dt0),
        .game_output_valid(gv), .game_output_data(gd), .game_status(gs),
        .busy(b0), .done(d0), .result(r0), .rx_msg(m0), .msg_error(er0), .session_open(o0)
    );

    lockpick_player #(.PACE(2), .TIMEOUT_CYCLES(TO)) dut2 (
        .clk(clk), .rst(rst), .go(go2), .key_a(key_a), .key_b(key_b),
        .game_start(s2), .game_input_enable(e2), .game_input_data(dt2),
        .game_output_valid(gv), .game_output_data(gd), .game_status(gs),
        .busy(b2), .done(d2), .result(r2), .rx_msg(m2), .msg_error(er2), .session_open(o2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (e0) begin sent0.push_back(dt0); sent0_cyc.push_back(cyc); end
        if (s0) begin starts0++; start0_cyc = cyc; end
        if (e2) begin sent2.push_back(dt2); sent2_cyc.push_back(cyc); end
        if (s2) starts2++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v = '0;
        for (int i = 0; i < 8; i++) v = (v << 32) | 256'($urandom);
        return v;
    endfunction

    // Outcome of one attempt from the frame the game sends: n bytes delivered back-to-back.
    function automatic outcome_t model(input logic [7:0] fr[32], input int n, input logic [1:0] st);
        outcome_t   o;
        logic [1:0] code;
        bit         bad = 0;
        o = '0;
        for (int i = 0; i < 4 && i < n; i++) o.msg = o.msg | (32'(fr[i]) << (8 * i));
        if (n < 32) begin
            o.err = 1'b1;
            return o;
        end
        for (int i = 4; i < 32; i++) if (fr[i] != fr[i % 4]) bad = 1;
        code = o.msg == 32'hFACEFACE ? 2'b10 : o.msg == 32'hBAD0BAD0 ? 2'b01 :
               o.msg == 32'hDEADDEAD ? 2'b11 : 2'b00;
        if (bad || code == 2'b00 || code != st) o.err = 1'b1;
        else begin
            o.res  = code;
            o.open = code == 2'b01;
        end
        return o;
    endfunction

    task automatic attempt(input string tag, input logic [255:0] ka, input logic [255:0] kb,
                           input logic [31:0] msg, input int bad_idx, input int n, input logic [1:0] st);
        logic [7:0] fr[32];
        outcome_t   exp;
        int         bad;
        logic       want_start;
        for (int i = 0; i < 32; i++) fr[i] = 8'(msg >> (8 * (i % 4)));
        if (bad_idx >= 0) fr[bad_idx] = 8'h00;
        want_start = !open_exp;
        sent0.delete(); sent0_cyc.delete(); starts0 = 0;
        key_a = ka; key_b = kb;
        @(negedge clk) go0 = 1;
        @(negedge clk) go0 = 0;
        for (int w = 0; w < 200 && sent0.size() < 64; w++) @(negedge clk);
        check({tag, " strobes"}, sent0.size(), 64);
        check({tag, " start"}, starts0, 32'(want_start));
        if (sent0.size() == 64) begin
            check({tag, " burst"}, sent0_cyc[63] - sent0_cyc[0], 63);
            if (want_start) check({tag, " start->byte0"}, sent0_cyc[0] - start0_cyc, 1);
            bad = 0;
            for (int i = 0; i < 64; i++) if (sent0[i] != 8'((i < 32 ? ka : kb) >> (8 * (i % 32)))) bad++;
            check({tag, " key bytes"}, bad, 0);
        end
        repeat (1 + $urandom_range(0, 4)) @(negedge clk);
        gs = st;
        for (int i = 0; i < n; i++) begin
            gv = 1; gd = fr[i];
            @(negedge clk);
        end
        gv = 0; gd = '0;
        for (int w = 0; w < 150 && !d0; w++) @(negedge clk);
        check({tag, " done"}, 32'(d0), 1);
        if (n == 0 && sent0_cyc.size() == 64)
            check({tag, " timeout latency"}, 32'(cyc - sent0_cyc[63] >= TO && cyc - sent0_cyc[63] <= TO + 3), 1);
        exp = model(fr, n, st);
        check({tag, " result"}, r0, exp.res);
        check({tag, " msg_error"}, er0, exp.err);
        check({tag, " session_open"}, o0, exp.open);
        check({tag, " rx_msg"}, m0, exp.msg);
        check({tag, " busy"}, b0, 0);
        @(negedge clk);
        check({tag, " done pulse"}, d0, 0);
        open_exp = exp.open;
    endtask

    initial begin
        logic [255:0] ra, rb;
        logic [31:0]  msg;
        logic [1:0]   st;
        int           n, bad, sel, nsent;
        #12;
        check("reset ctl0", {s0, e0, dt0, b0, d0, r0, er0, o0}, 0);
        check("reset msg0", m0, 0);
        check("reset ctl2", {s2, e2, dt2, b2, d2, r2, er2, o2}, 0);
        @(negedge clk) rst = 1;
        repeat (2) @(negedge clk);

        attempt("first", '0, '0, 32'hBAD0BAD0, -1, 32, 2'b01);
        if (sent0.size() > 0) check("first byte0_a", sent0[0], 0);
        attempt("second", rnd256(), rnd256(), 32'hBAD0BAD0, -1, 32, 2'b01);
        attempt("third", rnd256(), rnd256(), 32'hDEADDEAD, -1, 32, 2'b11);
        attempt("win", rnd256(), rnd256(), 32'hFACEFACE, -1, 32, 2'b10);
        attempt("silent", rnd256(), rnd256(), 32'h0, -1, 0, 2'b00);
        attempt("corrupt17", rnd256(), rnd256(), 32'hFACEFACE, 17, 32, 2'b10);
        attempt("gap10", rnd256(), rnd256(), 32'hFACEFACE, -1, 11, 2'b10);
        attempt("status mismatch", rnd256(), rnd256(), 32'hDEADDEAD, -1, 32, 2'b10);

        for (int k = 0; k < 10; k++) begin
            sel = $urandom_range(0, 3);
            msg = sel == 0 ? 32'hFACEFACE : sel == 1 ? 32'hBAD0BAD0 : sel == 2 ? 32'hDEADDEAD : $urandom;
            st  = sel == 0 ? 2'b10 : sel == 1 ? 2'b01 : sel == 2 ? 2'b11 : 2'($urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) st = 2'($urandom_range(1, 3));
            n = $urandom_range(0, 7) == 0 ? $urandom_range(1, 31) : 32;
            attempt($sformatf("rand%0d", k), rnd256(), rnd256(), msg,
                    $urandom_range(0, 3) == 0 ? $urandom_range(4, 31) : -1, n, st);
        end

        sent2.delete(); sent2_cyc.delete(); starts2 = 0;
        ra = rnd256(); rb = rnd256(); key_a = ra; key_b = rb;
        @(negedge clk) go2 = 1;
        @(negedge clk) go2 = 0;
        for (int w = 0; w < 400 && sent2.size() < 64; w++) @(negedge clk);
        check("pace strobes", sent2.size(), 64);
        check("pace start", starts2, 1);
        if (sent2.size() == 64) begin
            bad = 0;
            for (int i = 1; i < 64; i++) if (sent2_cyc[i] - sent2_cyc[i-1] != 3) bad++;
            check("pace spacing", bad, 0);
            bad = 0;
            for (int i = 0; i < 64; i++) if (sent2[i] != 8'((i < 32 ? ra : rb) >> (8 * (i % 32)))) bad++;
            check("pace key bytes", bad, 0);
        end
        repeat (4) @(negedge clk);
        gs = 2'b10;
        for (int i = 0; i < 32; i++) begin
            gv = 1; gd = i % 2 == 0 ? 8'hCE : 8'hFA;
            @(negedge clk);
        end
        gv = 0; gd = '0;
        for (int w = 0; w < 150 && !d2; w++) @(negedge clk);
        check("pace done", d2, 1);
        check("pace result", r2, 2'b10);
        check("pace rx_msg", m2, 32'hFACEFACE);
        check("pace msg_error", er2, 0);
        check("pace session_open", o2, 0);

        sent2.delete(); sent2_cyc.delete(); starts2 = 0;
        key_a = rnd256(); key_b = rnd256();
        @(negedge clk) go2 = 1;
        @(negedge clk) go2 = 0;
        for (int w = 0; w < 400 && sent2.size() < 40; w++) @(negedge clk);
        check("mid B reached", 32'(sent2.size() >= 40), 1);
        rst = 0;
        #1;
        check("async rst ctl2", {s2, e2, dt2, b2, d2, r2, er2, o2}, 0);
        check("async rst msg2", m2, 0);
        check("async rst ctl0", {s0, e0, dt0, b0, d0, r0, er0, o0}, 0);
        nsent = sent2.size();
        repeat (3) @(negedge clk);
        check("no strobes in rst", sent2.size(), nsent);
        rst = 1;
        @(negedge clk) begin starts2 = 0; go2 = 1; end
        @(negedge clk) go2 = 0;
        repeat (2) @(negedge clk);
        check("start after rst", starts2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
